// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: prescaled tick drives a 4-digit cascaded BCD count 0000-9999.
// Latency: push-button events act at the edge ending the event cycle; digits/rollover are registered.
// Backpressure: none; pulse inputs are edge-detected and each rising edge is acted on or discarded.
module stopwatch_ctrl #(
    parameter int DIV   = 100000,
    parameter int DIV_W = 17
) (
    input  logic        clk,
    input  logic        ar,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic        run,
    output logic        lap_hold,
    output logic        tick,
    output logic [15:0] digits,
    output logic        rollover
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(DIV - 1);

    state_t            state_q, state_d;
    logic              ss_in_q, lap_in_q, clr_in_q;
    logic [15:0]       count_q, count_d;
    logic [15:0]       lapreg_q, lapreg_d;
    logic [15:0]       count_inc;
    logic [DIV_W-1:0]  pre_q, pre_d;
    logic              roll_q, roll_d;
    logic              ev_ss, ev_lap, ev_clr;
    logic              counting;

    // Rising-edge events and the count tick, all from registered state.
    always_comb begin
        ev_ss    = start_stop & ~ss_in_q;
        ev_lap   = lap & ~lap_in_q;
        ev_clr   = clear & ~clr_in_q;
        counting = (state_q == RUN) || (state_q == LAP);
        tick     = counting && (pre_q == PRE_MAX);
    end

    // Ripple the tick through the decimal digits; a digit advances when all lower digits are 9.
    always_comb begin
        logic c;
        count_inc = count_q;
        c = tick;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                end else begin
                    count_inc[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

    // Next state plus prescaler, count and lap-register updates; clear beats start_stop beats lap.
    always_comb begin
        state_d  = state_q;
        count_d  = count_inc;
        lapreg_d = lapreg_q;
        roll_d   = tick && (count_q == 16'h9999);
        pre_d    = pre_q;
        if (counting) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (ev_ss) state_d = RUN;
            end
            RUN: begin
                if (ev_ss) begin
                    state_d = STOP;
                end else if (ev_lap) begin
                    state_d  = LAP;
                    lapreg_d = count_inc;
                end
            end
            LAP: begin
                if (ev_ss)       state_d = STOP;
                else if (ev_lap) state_d = RUN;
            end
            STOP: begin
                if (ev_clr) begin
                    state_d = IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (ev_ss) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and edge-detect registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (ar) begin
            state_q  <= IDLE;
            count_q  <= '0;
            lapreg_q <= '0;
            pre_q    <= '0;
            roll_q   <= 1'b0;
            ss_in_q  <= 1'b0;
            lap_in_q <= 1'b0;
            clr_in_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lapreg_q <= lapreg_d;
            pre_q    <= pre_d;
            roll_q   <= roll_d;
            ss_in_q  <= start_stop;
            lap_in_q <= lap;
            clr_in_q <= clear;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        run      = (state_q == RUN) || (state_q == LAP);
        lap_hold = (state_q == LAP);
        digits   = (state_q == LAP) ? lapreg_q : count_q;
        rollover = roll_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic        run, lap_hold, tick, rollover;
    logic [15:0] digits;

    int vectors = 0;
    int miscompares = 0;

    stopwatch_ctrl #(.DIV(DIV), .DIV_W(3)) dut (
        .clk(clk), .ar(ar), .start_stop(start_stop), .lap(lap), .clear(clear),
        .run(run), .lap_hold(lap_hold), .tick(tick), .digits(digits), .rollover(rollover)
    );

    always #5 clk = ~clk;

    // Reference model: integer count, prescaler phase and mode flags.
    int m_cnt = 0, m_pre = 0, m_lapv = 0;
    bit m_run = 0, m_frz = 0, m_paused = 0, m_roll = 0;
    bit p_ss = 0, p_lp = 0, p_cl = 0;

    logic [18:0] obs_v, exp_v;
    logic        obs_tick, exp_tick;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit s, input bit l, input bit c, input bit r);
        bit e_ss, e_lp, e_cl, tk;
        int ncnt, npre;
        if (r) begin
            m_cnt = 0; m_pre = 0; m_lapv = 0;
            m_run = 0; m_frz = 0; m_paused = 0; m_roll = 0;
            p_ss = 0; p_lp = 0; p_cl = 0;
            return;
        end
        e_ss = s && !p_ss;
        e_lp = l && !p_lp;
        e_cl = c && !p_cl;
        tk   = m_run && (m_pre == DIV - 1);
        ncnt = tk ? (m_cnt + 1) % 10000 : m_cnt;
        npre = m_run ? (tk ? 0 : m_pre + 1) : m_pre;
        m_roll = tk && (m_cnt == 9999);
        if (m_run) begin
            if (e_ss) begin
                m_run = 0; m_paused = 1; m_frz = 0;
            end else if (e_lp) begin
                if (m_frz) m_frz = 0;
                else begin m_frz = 1; m_lapv = ncnt; end
            end
        end else if (m_paused) begin
            if (e_cl) begin
                m_paused = 0; ncnt = 0; npre = 0;
            end else if (e_ss) begin
                m_paused = 0; m_run = 1;
            end
        end else if (e_ss) begin
            m_run = 1;
        end
        m_cnt = ncnt;
        m_pre = npre;
        p_ss = s; p_lp = l; p_cl = c;
    endtask

    // One clock: apply input levels, sample tick mid-cycle, advance model, sample outputs after the edge.
    task automatic drive(input bit s, input bit l, input bit c, input bit r);
        start_stop = s; lap = l; clear = c; ar = r;
        @(negedge clk);
        obs_tick = tick;
        exp_tick = m_run && (m_pre == DIV - 1);
        @(posedge clk);
        model_step(s, l, c, r);
        #1;
        obs_v = {run, lap_hold, rollover, digits};
        exp_v = {m_run, m_frz, m_roll, bcd(m_frz ? m_lapv : m_cnt)};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            vectors++;
            if (obs_v !== 19'd0) begin
                miscompares++;
                $display("FAIL reset: outputs run/hold/roll/digits=%h required 0", obs_v);
            end
        end
        drive(0, 0, 0, 0);
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL reset_idle: got %h required %h", obs_v, exp_v);
        end
    endtask

    task automatic test_count();
        int first = -1;
        drive(1, 0, 0, 0);
        for (int n = 1; n <= 40; n++) begin
            drive(0, 0, 0, 0);
            if (obs_tick && first < 0) first = n;
            vectors++;
            if (obs_v !== exp_v || obs_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL count: got %h tick=%b required %h tick=%b", obs_v, obs_tick, exp_v, exp_tick);
            end
        end
        vectors++;
        if (first != 4) begin
            miscompares++;
            $display("FAIL first_tick: got cycle %0d required 4", first);
        end
        vectors++;
        if (digits !== 16'h0010 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL count_10: digits=%h run=%b required 0010 run=1", digits, run);
        end
    endtask

    task automatic run_until_tick(input string nm);
        int n = 0;
        do begin
            drive(0, 0, 0, 0);
            n++;
            vectors++;
            if (obs_v !== exp_v || obs_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL %s: got %h tick=%b required %h tick=%b", nm, obs_v, obs_tick, exp_v, exp_tick);
            end
        end while (!obs_tick && n < 20);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 50000 && m_cnt != 99; n++) drive(0, 0, 0, 0);
        run_until_tick("carry99");
        vectors++;
        if (digits !== 16'h0100) begin
            miscompares++;
            $display("FAIL carry_0100: digits=%h required 0100", digits);
        end
        for (int n = 0; n < 50000 && m_cnt != 9999; n++) begin
            drive(0, 0, 0, 0);
            if (m_cnt % 997 == 0) begin
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL climb: got %h required %h", obs_v, exp_v);
                end
            end
        end
        vectors++;
        if (digits !== 16'h9999) begin
            miscompares++;
            $display("FAIL at_9999: digits=%h required 9999", digits);
        end
        run_until_tick("wrap");
        vectors++;
        if (digits !== 16'h0000 || rollover !== 1'b1 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap: digits=%h roll=%b run=%b required 0000 1 1", digits, rollover, run);
        end
        drive(0, 0, 0, 0);
        vectors++;
        if (rollover !== 1'b0 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL roll_pulse: roll=%b run=%b required 0 1", rollover, run);
        end
    endtask

    task automatic test_lap();
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 200 && m_cnt != 5; n++) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        for (int n = 0; n < 200 && m_cnt != 12; n++) begin
            drive(0, 0, 0, 0);
            vectors++;
            if (digits !== 16'h0005 || lap_hold !== 1'b1 || obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL lap_freeze: got %h required %h (digits 0005)", obs_v, exp_v);
            end
        end
        drive(0, 1, 0, 0);
        vectors++;
        if (digits !== 16'h0012 || lap_hold !== 1'b0 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL lap_release: digits=%h hold=%b run=%b required 0012 0 1", digits, lap_hold, run);
        end
    endtask

    task automatic test_stop();
        logic [15:0] held;
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 3 || (n < 100 && m_pre != 2); n++) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        held = digits;
        for (int n = 0; n < 20; n++) begin
            drive(0, 0, 0, 0);
            vectors++;
            if (digits !== held || run !== 1'b0 || obs_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL stop_hold: digits=%h run=%b tick=%b required %h 0 0", digits, run, obs_tick, held);
            end
        end
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        vectors++;
        if (obs_tick !== 1'b1 || run !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_tick: tick=%b run=%b required 1 1", obs_tick, run);
        end
        drive(0, 0, 1, 0);
        vectors++;
        if (run !== 1'b1 || obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL clear_in_run: got %h required %h", obs_v, exp_v);
        end
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        vectors++;
        if (digits !== 16'h0000 || run !== 1'b0 || obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL clear_in_stop: digits=%h run=%b required 0000 0", digits, run);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 9; n++) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 0);
        vectors++;
        if (digits !== 16'h0000 || run !== 1'b0 || obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL clr_ss_stop: digits=%h run=%b required 0000 0", digits, run);
        end
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 3; n++) drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        vectors++;
        if (lap_hold !== 1'b0 || run !== 1'b0 || obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL ss_lap_run: hold=%b run=%b required 0 0", lap_hold, run);
        end
        drive(0, 0, 0, 0);
        for (int n = 0; n < 50; n++) begin
            drive(1, 0, 0, 0);
            vectors++;
            if (run !== 1'b1 || obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL ss_held: cycle %0d run=%b got %h required %h", n, run, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        for (int n = 0; n < 5000 && m_cnt != 321; n++) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        vectors++;
        if (lap_hold !== 1'b1 || digits !== 16'h0321) begin
            miscompares++;
            $display("FAIL lap_321: hold=%b digits=%h required 1 0321", lap_hold, digits);
        end
        drive(0, 0, 0, 1);
        vectors++;
        if (obs_v !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_in_lap: got %h required 0", obs_v);
        end
        drive(1, 0, 0, 0);
        for (int n = 1; n <= 8; n++) begin
            drive(0, 0, 0, 0);
            if (obs_tick && first < 0) first = n;
        end
        vectors++;
        if (first != DIV) begin
            miscompares++;
            $display("FAIL tick_after_reset: got cycle %0d required %0d", first, DIV);
        end
    endtask

    task automatic test_random();
        drive(0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
            vectors++;
            if (obs_v !== exp_v || obs_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL random: cycle %0d got %h tick=%b required %h tick=%b",
                         n, obs_v, obs_tick, exp_v, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_lap();
        test_stop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences a 4-digit cascaded BCD count (0000–9999) as a start/stop/lap/clear stopwatch. A prescaler generates the count tick, and a digit-enable chain ripples the tick across the cascaded decimal digits. A run-control FSM gates the prescaler, and a lap register freezes the displayed value while counting continues. It sits between debounced push-button pulses and the 7-segment display decoders.

Parameters:
DIV, 100000, clk cycles per count tick (must be >= 2)
DIV_W, 17, prescaler width (must satisfy 2**DIV_W >= DIV)

Ports:
clk  input  1  system clock, rising-edge active
ar  input  1  synchronous reset, active-high
start_stop  input  1  toggle run/pause (internally rising-edge detected)
lap  input  1  toggle display freeze (internally rising-edge detected)
clear  input  1  zero the count (internally rising-edge detected)
run  output  1  high in RUN or LAP
lap_hold  output  1  high in LAP
tick  output  1  combinational; high when the count advances at this clk edge
digits  output  16  display value; [3:0] units … [15:12] thousands; BCD
rollover  output  1  one-cycle registered pulse after a 9999->0000 wrap

Behaviour:
- Reset: ar sampled high at a clk edge.
  - state=IDLE; internal count=0000; lap register=0000; prescaler=0.
  - Edge-detect registers=0; rollover=0.
  - ar has priority over everything and is honoured mid-run.
- Edge detect:
  - ev_x = x & ~x_q, where x_q is x registered every cycle.
  - A level held high produces one event only.
  - An input high in the first cycle after reset produces an event.
- Event priority in one cycle: clear > start_stop > lap. A lower-priority event coincident with an acted-on higher one is discarded.
- States and transitions (taken at the clk edge ending the event cycle):
  - IDLE: ev_start_stop -> RUN. ev_clear and ev_lap ignored.
  - RUN: ev_start_stop -> STOP. ev_lap -> LAP and lap register <= live count (including any increment at this same edge). ev_clear ignored.
  - LAP: ev_lap -> RUN. ev_start_stop -> STOP; display returns to live count. ev_clear ignored.
  - STOP: ev_start_stop -> RUN. ev_clear -> IDLE, count <= 0000, prescaler <= 0. ev_lap ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN/LAP.
  - tick = (state in RUN/LAP) & (prescaler == DIV-1).
  - On tick, the prescaler wraps to 0.
  - In STOP it holds its value, so resume keeps the fractional period.
- Digit cascade:
  - Digit i increments on tick when all lower digits == 9; otherwise it holds.
  - A digit at 9 that increments goes to 0.
  - Digits never leave 0..9.
  - Count updates at the edge where tick is high.
- Wrap: tick with count=9999 -> count=0000, rollover=1 for exactly the next cycle. Counting continues.
- Exit from RUN/LAP on the tick cycle: if the start_stop event and tick coincide, the increment is still applied and the state becomes STOP.
- digits output: lap register in LAP, otherwise live count. Registered sources only, no combinational path from inputs.
- run and lap_hold are decoded from registered state.

Test Plan:
1. DIV=4; reset, one start_stop pulse, run 40 cycles -> first tick 4 cycles after entering RUN; digits=0010 after 10 ticks; run=1.
2. Preload via ticks to 0099, next tick -> 0100; preload to 9999, tick -> 0000 and rollover high exactly one cycle; run stays 1.
3. RUN at 0005; lap pulse -> lap_hold=1, digits frozen at 0005 while the internal count reaches 0012. Second lap pulse -> digits=0012 immediately.
4. start_stop at prescaler=2 -> STOP; hold 20 cycles -> digits unchanged. start_stop -> next tick after exactly 1 more RUN cycle. clear in RUN ignored; clear in STOP -> digits=0000, state IDLE.
5. Simultaneous rising edges of clear+start_stop in STOP -> IDLE with digits=0000, run=0. start_stop+lap in RUN -> STOP, lap_hold=0. start_stop held high 50 cycles -> a single transition.
6. ar asserted in LAP at count 0321 -> next cycle digits=0000, run=0, lap_hold=0, rollover=0. Start after reset -> first tick after DIV cycles.
